// File: rtl/jk_bank_sched.sv
// jk_bank_sched: round-robin sequencer sharing a JK flip-flop bank between two requesters.
// Optional JK_VERIFY_EN adds a sticky check of each cell's result against the expected JK behaviour.
module jk_bank_sched #(
  parameter int NUM_FF = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [IDX_W-1:0]  req0_idx,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [IDX_W-1:0]  req1_idx,
  input  logic [1:0]        req1_op,
  output logic [NUM_FF-1:0] j_out,
  output logic [NUM_FF-1:0] k_out,
  input  logic [NUM_FF-1:0] q_in,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              done_q,
  output logic              bad_idx,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, RESP} state_t;
  state_t             r_state;
  logic               r_rr_last, r_id, r_busy, r_done, r_done_id, r_done_q, r_bad;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_FF-1:0]  r_j, r_k;
  logic               w_gnt, w_acc, w_bad;
  logic [IDX_W-1:0]   w_idx;
  logic [1:0]         w_op;
  logic [NUM_FF-1:0]  w_mask;
  // Both valid: alternate away from the last winner; otherwise whoever asks.
  assign w_gnt      = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;
  assign w_acc      = (r_state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = w_acc && !w_gnt;
  assign req1_ready = w_acc && w_gnt;
  assign w_idx      = w_gnt ? req1_idx : req0_idx;
  assign w_op       = w_gnt ? req1_op : req0_op;
  assign w_bad      = 32'(w_idx) >= NUM_FF;
  assign w_mask     = NUM_FF'(1) << w_idx;
  assign j_out      = r_j;
  assign k_out      = r_k;
  assign busy       = r_busy;
  assign done       = r_done;
  assign done_id    = r_done_id;
  assign done_q     = r_done_q;
  assign bad_idx    = r_bad;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_id      <= 1'b0;
      r_idx     <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_done_q  <= 1'b0;
      r_bad     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_idx     <= w_idx;
          r_id      <= w_gnt;
          r_rr_last <= w_gnt;
          r_busy    <= 1'b1;
          if (w_bad) begin
            r_state   <= RESP;
            r_done    <= 1'b1;
            r_done_id <= w_gnt;
            r_done_q  <= 1'b0;
            r_bad     <= 1'b1;
          end else begin
            r_state <= APPLY;
            r_j     <= w_op[1] ? w_mask : '0;
            r_k     <= w_op[0] ? w_mask : '0;
          end
        end
        APPLY: begin
          r_j     <= '0;
          r_k     <= '0;
          r_state <= SETTLE;
        end
        SETTLE: begin
          r_done    <= 1'b1;
          r_done_id <= r_id;
          r_done_q  <= q_in[r_idx];
          r_bad     <= 1'b0;
          r_state   <= RESP;
        end
        default: begin
          r_done  <= 1'b0;
          r_bad   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
`ifdef JK_VERIFY_EN
  logic [1:0] r_op;
  logic       r_qprev, r_err, w_exp;
  assign w_exp = (r_op == 2'b00) ? r_qprev : (r_op == 2'b01) ? 1'b0 : (r_op == 2'b10) ? 1'b1 : ~r_qprev;
  assign err   = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_qprev <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_acc) r_op <= w_op;
      if (r_state == APPLY) r_qprev <= q_in[r_idx];
      if (r_state == SETTLE && q_in[r_idx] != w_exp) r_err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_jk_bank_sched.sv
// tb_jk_bank_sched: directed checks of jk_bank_sched against a behavioural JK bank.
module tb_jk_bank_sched;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       r0v = 1'b0, r1v = 1'b0, r0rdy, r1rdy;
  logic [2:0] ridx = '0;
  logic [1:0] rop = '0;
  logic [7:0] j, k, q_in;
  logic       busy, done, done_id, done_q, bad, err;
  logic [7:0] bank = '0;
  logic       f3 = 1'b0;
  logic       b_v = 1'b0, b_rdy, b_busy, b_done, b_id, b_q, b_bad, b_err;
  logic [2:0] b_idx = '0;
  logic [1:0] b_op = '0;
  logic [5:0] b_j, b_k;
  int         n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      bank[i] <= (j[i] && k[i]) ? ~bank[i] : j[i] ? 1'b1 : k[i] ? 1'b0 : bank[i];
  assign q_in = bank & ~(f3 ? 8'h08 : 8'h00);

  jk_bank_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_idx(ridx), .req0_op(rop),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_idx(ridx), .req1_op(rop),
    .j_out(j), .k_out(k), .q_in(q_in),
    .busy(busy), .done(done), .done_id(done_id), .done_q(done_q), .bad_idx(bad), .err(err)
  );

  jk_bank_sched #(.NUM_FF(6), .IDX_W(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v), .req0_ready(b_rdy), .req0_idx(b_idx), .req0_op(b_op),
    .req1_valid(1'b0), .req1_ready(), .req1_idx(3'd0), .req1_op(2'd0),
    .j_out(b_j), .k_out(b_k), .q_in(6'h3f),
    .busy(b_busy), .done(b_done), .done_id(b_id), .done_q(b_q), .bad_idx(b_bad), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_op(input logic id, input logic [2:0] idx, input logic [1:0] op,
                        input logic [7:0] ej, input logic [7:0] ek, input logic eq);
    r0v = !id; r1v = id; ridx = idx; rop = op;
    #1 chk("ready0", r0rdy, !id); chk("ready1", r1rdy, id);
    @(negedge clk); r0v = 0; r1v = 0;
    chk("j_apply", j, ej); chk("k_apply", k, ek); chk("busy_apply", busy, 1);
    @(negedge clk);
    chk("j_settle", j, 0); chk("k_settle", k, 0); chk("done_early", done, 0);
    @(negedge clk);
    chk("done", done, 1); chk("done_id", done_id, id); chk("done_q", done_q, eq); chk("bad_idx", bad, 0);
    @(negedge clk);
    chk("done_clr", done, 0); chk("busy_clr", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_j", j, 0); chk("rst_err", err, 0);
    rst_n = 1;
    @(negedge clk);
    run_op(0, 3'd2, 2'b10, 8'h04, 8'h00, 1);
    run_op(1, 3'd5, 2'b10, 8'h20, 8'h00, 1);
    run_op(1, 3'd5, 2'b11, 8'h20, 8'h20, 0);
    run_op(0, 3'd2, 2'b01, 8'h00, 8'h04, 0);
    run_op(0, 3'd5, 2'b00, 8'h00, 8'h00, 0);
    // contention: rr_last=0 after the last req0 grant, so req1 wins first
    r0v = 1; r1v = 1; ridx = 3'd1; rop = 2'b11;
    for (int c = 0; c < 16; c++) begin
      #1 chk("cont_r1", r1rdy, c % 8 == 0); chk("cont_r0", r0rdy, c % 8 == 4);
      @(negedge clk);
    end
    r0v = 0; r1v = 0;
    // reset in the middle of APPLY
    r0v = 1; ridx = 3'd4; rop = 2'b11;
    @(negedge clk); r0v = 0;
    chk("mid_j", j, 8'h10);
    rst_n = 0;
    #1 chk("rst_mid_j", j, 0); chk("rst_mid_k", k, 0); chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0); chk("rst_mid_err", err, 0);
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("no_done_after_rst", done, 0);
    end
    chk("bank4_untouched", bank[4], 0);
    // bad index on the 6-cell instance
    b_v = 1; b_idx = 3'd7; b_op = 2'b10;
    #1 chk("bad_ready", b_rdy, 1);
    @(negedge clk); b_v = 0;
    chk("bad_done", b_done, 1); chk("bad_flag", b_bad, 1); chk("bad_q", b_q, 0);
    chk("bad_j", b_j, 0); chk("bad_k", b_k, 0); chk("bad_busy", b_busy, 1); chk("bad_id", b_id, 0);
    @(negedge clk);
    chk("bad_done_clr", b_done, 0); chk("bad_busy_clr", b_busy, 0); chk("bad_err", b_err, 0);
    // cell 3 forced low: set op cannot take effect
    f3 = 1;
    r0v = 1; ridx = 3'd3; rop = 2'b10;
    @(negedge clk); r0v = 0;
    repeat (2) @(negedge clk);
    chk("f3_done", done, 1); chk("f3_q", done_q, 0);
`ifdef JK_VERIFY_EN
    chk("err_set", err, 1);
    repeat (4) @(negedge clk);
    chk("err_sticky", err, 1);
    rst_n = 0;
    #1 chk("err_rst", err, 0);
    @(negedge clk); rst_n = 1;
`else
    chk("err_tied", err, 0);
`endif
    f3 = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
